// File: rtl/ps2_pkg.sv
// Shared constants and decode-state type for the PS/2 key tracker.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } dec_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizer, falling-edge detect, 11-bit shift,
// frame check and mid-frame timeout.
module ps2_rx #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       frame_ok,
  output logic [7:0] frame_byte
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    clk_sync;
  logic [2:0]    data_sync;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift;
  logic [TW-1:0] timer;
  logic [10:0]   frame;
  logic          fall;
  logic          last;
  logic          good;

  assign fall = clk_sync[2] & ~clk_sync[1];
  assign last = fall && (bit_cnt == 4'd10);

  // The 11th bit is taken straight from the synchronizer so the check needs no extra cycle.
  assign frame      = {data_sync[1], shift};
  assign good       = ~frame[0] & (^frame[9:1]) & frame[10];
  assign frame_ok   = last & good;
  assign frame_byte = frame[8:1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
      bit_cnt   <= '0;
      shift     <= '0;
      timer     <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
      rx_valid  <= frame_ok;
      rx_err    <= last & ~good;
      if (frame_ok) rx_byte <= frame_byte;

      if (fall) begin
        shift   <= {data_sync[1], shift[9:1]};
        bit_cnt <= last ? 4'd0 : bit_cnt + 4'd1;
        timer   <= '0;
      end else if (bit_cnt != 4'd0) begin
        // A stalled partial frame is dropped without raising rx_err.
        if (timer == TW'(TIMEOUT_CYC - 1)) begin
          bit_cnt <= '0;
          timer   <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: make/break/extended decode, held-key tracking and
// press counting, presented as nibbles for hex seven-segment decoders.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_held,
  output logic [7:0] press_cnt,
  output logic [3:0] code_hi,
  output logic [3:0] code_lo,
  output logic [3:0] cnt_hi,
  output logic [3:0] cnt_lo,
  output logic       blank
);

  dec_state_t state, state_nxt;
  logic       frame_ok;
  logic [7:0] b;
  logic       do_make;
  logic       do_break;
  logic       ev_ext;
  logic       same_key;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .frame_ok   (frame_ok),
    .frame_byte (b)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    do_make   = 1'b0;
    do_break  = 1'b0;
    ev_ext    = 1'b0;
    if (frame_ok) begin
      unique case (state)
        IDLE: begin
          if (b == PS2_EXT)        state_nxt = EXT;
          else if (b == PS2_BREAK) state_nxt = BRK;
          else                     do_make   = 1'b1;
        end
        EXT: begin
          if (b == PS2_BREAK) begin
            state_nxt = EXT_BRK;
          end else if (b != PS2_EXT) begin
            do_make   = 1'b1;
            ev_ext    = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          do_break  = 1'b1;
          state_nxt = IDLE;
        end
        EXT_BRK: begin
          do_break  = 1'b1;
          ev_ext    = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A make of the key already down is typematic repeat; a break of any other key is ignored.
  assign same_key = key_held && ({ev_ext, b} == {key_ext, key_code});

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_held  <= 1'b0;
      press_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (do_make && !same_key) begin
        key_code  <= b;
        key_ext   <= ev_ext;
        key_held  <= 1'b1;
        press_cnt <= press_cnt + 8'd1;
      end
      if (do_break && same_key) key_held <= 1'b0;
    end
  end

  assign code_hi = key_code[7:4];
  assign code_lo = key_code[3:0];
  assign cnt_hi  = press_cnt[7:4];
  assign cnt_lo  = press_cnt[3:0];
  assign blank   = ~key_held;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed vector table, hand-written
// timeout / reset / wrap sequences, and random frames against a behavioural model.
module tb_ps2_key_tracker;

  localparam int TO = 256;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_held;
  logic [7:0] press_cnt;
  logic [3:0] code_hi, code_lo, cnt_hi, cnt_lo;
  logic       blank;

  ps2_key_tracker #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_held  (key_held),
    .press_cnt (press_cnt),
    .code_hi   (code_hi),
    .code_lo   (code_lo),
    .cnt_hi    (cnt_hi),
    .cnt_lo    (cnt_lo),
    .blank     (blank)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse monitor: counts rx events and snapshots key state in the rx_valid cycle.
  int         v_cnt = 0;
  int         e_cnt = 0;
  logic [7:0] v_byte = '0;
  logic [7:0] s_code = '0;
  logic       s_ext = 1'b0;
  logic       s_held = 1'b0;
  logic [7:0] s_cnt = '0;
  logic       prev_v = 1'b0;
  logic       prev_e = 1'b0;

  always @(negedge clk) begin
    if (rx_valid || rx_err) begin
      check("valid_err_exclusive", {31'b0, rx_valid & rx_err}, 32'd0);
      check("pulse_width", {31'b0, (rx_valid & prev_v) | (rx_err & prev_e)}, 32'd0);
    end
    if (rx_valid) begin
      v_cnt++;
      v_byte = rx_byte;
      s_code = key_code;
      s_ext  = key_ext;
      s_held = key_held;
      s_cnt  = press_cnt;
    end
    if (rx_err) e_cnt++;
    prev_v = rx_valid;
    prev_e = rx_err;
  end

  // Behavioural model: prefix flags plus the single tracked key.
  logic [7:0] m_code;
  logic       m_ext, m_held, p_ext, p_brk;
  logic [7:0] m_cnt;

  function automatic void model_reset();
    m_code = '0; m_ext = 0; m_held = 0; p_ext = 0; p_brk = 0; m_cnt = '0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (p_brk) begin
      if (m_held && m_code == b && m_ext == p_ext) m_held = 0;
      p_brk = 0; p_ext = 0;
    end else if (b == 8'hF0) begin
      p_brk = 1;
    end else if (b == 8'hE0) begin
      p_ext = 1;
    end else begin
      if (!(m_held && m_code == b && m_ext == p_ext)) begin
        m_code = b; m_ext = p_ext; m_held = 1; m_cnt = m_cnt + 8'd1;
      end
      p_ext = 0;
    end
  endfunction

  function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(posedge clk); ps2_data = f[i];
      @(posedge clk); ps2_clk = 1'b0;
      repeat (3) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic xfer(input logic [7:0] b, input bit bp, input bit bs, output int dv, output int de);
    int v0, e0;
    v0 = v_cnt;
    e0 = e_cnt;
    send_bits(mk(b, bp, bs), 0, 11);
    repeat (4) @(posedge clk);
    @(negedge clk);
    dv = v_cnt - v0;
    de = e_cnt - e0;
    if (!bp && !bs) model_byte(b);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".key_code"},  {24'b0, key_code},  {24'b0, m_code});
    check({tag, ".key_ext"},   {31'b0, key_ext},   {31'b0, m_ext});
    check({tag, ".key_held"},  {31'b0, key_held},  {31'b0, m_held});
    check({tag, ".press_cnt"}, {24'b0, press_cnt}, {24'b0, m_cnt});
    check({tag, ".blank"},     {31'b0, blank},     {31'b0, !m_held});
    check({tag, ".code_nib"},  {24'b0, code_hi, code_lo}, {24'b0, m_code});
    check({tag, ".cnt_nib"},   {24'b0, cnt_hi, cnt_lo},   {24'b0, m_cnt});
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".rx"}, {22'b0, rx_byte, rx_valid, rx_err}, 32'd0);
    check({tag, ".key"}, {14'b0, key_code, key_ext, key_held, press_cnt}, 32'd0);
    check({tag, ".nib"}, {16'b0, code_hi, code_lo, cnt_hi, cnt_lo}, 32'd0);
    check({tag, ".blank"}, {31'b0, blank}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         bp;
    bit         bs;
    logic [7:0] code;
    bit         ext;
    bit         held;
    logic [7:0] cnt;
    bit         err;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int dv, de;
    logic [7:0] rb;
    bit bp, bs;
    string tag;

    vecs[0]  = '{8'h1C, 0, 0, 8'h1C, 0, 1, 8'd1, 0};
    vecs[1]  = '{8'hF0, 0, 0, 8'h1C, 0, 1, 8'd1, 0};
    vecs[2]  = '{8'h1C, 0, 0, 8'h1C, 0, 0, 8'd1, 0};
    vecs[3]  = '{8'h1C, 0, 0, 8'h1C, 0, 1, 8'd2, 0};
    vecs[4]  = '{8'h1C, 0, 0, 8'h1C, 0, 1, 8'd2, 0};
    vecs[5]  = '{8'h1C, 0, 0, 8'h1C, 0, 1, 8'd2, 0};
    vecs[6]  = '{8'h1C, 0, 0, 8'h1C, 0, 1, 8'd2, 0};
    vecs[7]  = '{8'h1C, 0, 0, 8'h1C, 0, 1, 8'd2, 0};
    vecs[8]  = '{8'hF0, 0, 0, 8'h1C, 0, 1, 8'd2, 0};
    vecs[9]  = '{8'h1C, 0, 0, 8'h1C, 0, 0, 8'd2, 0};
    vecs[10] = '{8'hE0, 0, 0, 8'h1C, 0, 0, 8'd2, 0};
    vecs[11] = '{8'h75, 0, 0, 8'h75, 1, 1, 8'd3, 0};
    vecs[12] = '{8'hF0, 0, 0, 8'h75, 1, 1, 8'd3, 0};
    vecs[13] = '{8'h75, 0, 0, 8'h75, 1, 1, 8'd3, 0};
    vecs[14] = '{8'hE0, 0, 0, 8'h75, 1, 1, 8'd3, 0};
    vecs[15] = '{8'hF0, 0, 0, 8'h75, 1, 1, 8'd3, 0};
    vecs[16] = '{8'h75, 0, 0, 8'h75, 1, 0, 8'd3, 0};
    vecs[17] = '{8'h1C, 1, 0, 8'h75, 1, 0, 8'd3, 1};
    vecs[18] = '{8'h1C, 0, 1, 8'h75, 1, 0, 8'd3, 1};
    vecs[19] = '{8'h2A, 0, 0, 8'h2A, 0, 1, 8'd4, 0};

    model_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    clrn = 1'b1;
    repeat (3) @(posedge clk);

    // Directed table: tap, typematic, extended, mismatched break, frame errors.
    for (int i = 0; i < 20; i++) begin
      tag = $sformatf("vec%0d", i);
      xfer(vecs[i].b, vecs[i].bp, vecs[i].bs, dv, de);
      check({tag, ".valid_cnt"}, dv, vecs[i].err ? 0 : 1);
      check({tag, ".err_cnt"}, de, vecs[i].err ? 1 : 0);
      if (!vecs[i].err) begin
        check({tag, ".rx_byte"}, {24'b0, v_byte}, {24'b0, vecs[i].b});
        check({tag, ".snap"}, {15'b0, s_code, s_ext, s_held, s_cnt},
              {15'b0, vecs[i].code, vecs[i].ext, vecs[i].held, vecs[i].cnt});
      end
      check({tag, ".key"}, {14'b0, key_code, key_ext, key_held, press_cnt},
            {14'b0, vecs[i].code, vecs[i].ext, vecs[i].held, vecs[i].cnt});
      check({tag, ".nib"}, {16'b0, code_hi, code_lo, cnt_hi, cnt_lo},
            {16'b0, vecs[i].code, vecs[i].cnt});
      check({tag, ".blank"}, {31'b0, blank}, {31'b0, !vecs[i].held});
    end

    // Partial frame abandoned past the timeout, then a clean frame.
    begin
      int v0, e0;
      v0 = v_cnt; e0 = e_cnt;
      send_bits(mk(8'h55, 0, 0), 0, 5);
      repeat (TO + 20) @(posedge clk);
      xfer(8'h1C, 0, 0, dv, de);
      check("timeout.valid_cnt", v_cnt - v0, 1);
      check("timeout.err_cnt", e_cnt - e0, 0);
      check("timeout.rx_byte", {24'b0, v_byte}, 32'h1C);
      check_state("timeout");

      // A gap shorter than the timeout keeps the partial frame alive.
      v0 = v_cnt; e0 = e_cnt;
      send_bits(mk(8'h33, 0, 0), 0, 5);
      repeat (TO / 2) @(posedge clk);
      send_bits(mk(8'h33, 0, 0), 5, 11);
      repeat (4) @(posedge clk);
      @(negedge clk);
      model_byte(8'h33);
      check("short_gap.valid_cnt", v_cnt - v0, 1);
      check("short_gap.err_cnt", e_cnt - e0, 0);
      check("short_gap.rx_byte", {24'b0, v_byte}, 32'h33);
      check_state("short_gap");
    end

    // Reset mid-frame clears immediately; next frame after release is clean.
    send_bits(mk(8'h1C, 0, 0), 0, 6);
    @(posedge clk);
    #1 clrn = 1'b0;
    #1 check_reset("mid_reset");
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    xfer(8'h1C, 0, 0, dv, de);
    check("post_reset.valid_cnt", dv, 1);
    check("post_reset.err_cnt", de, 0);
    check("post_reset.rx_byte", {24'b0, v_byte}, 32'h1C);
    check_state("post_reset");

    // Press counter wrap: 256 alternating distinct makes from a fresh reset.
    @(negedge clk);
    clrn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < 256; i++) begin
      xfer((i % 2 == 1) ? 8'h1B : 8'h1C, 0, 0, dv, de);
      if (i == 254) check("wrap.cnt_255", {24'b0, press_cnt}, 32'd255);
    end
    check("wrap.cnt_0", {24'b0, press_cnt}, 32'd0);
    check("wrap.cnt_nib", {24'b0, cnt_hi, cnt_lo}, 32'd0);
    check_state("wrap");

    // Random frames against the model, with occasional corrupted frames.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 7))
        0:       rb = 8'hF0;
        1:       rb = 8'hE0;
        2:       rb = 8'h1C;
        3:       rb = 8'h1B;
        4:       rb = 8'h75;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      bp = 0; bs = 0;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) bp = 1; else bs = 1;
      end
      tag = $sformatf("rand%0d", i);
      xfer(rb, bp, bs, dv, de);
      check({tag, ".valid_cnt"}, dv, (bp || bs) ? 0 : 1);
      check({tag, ".err_cnt"}, de, (bp || bs) ? 1 : 0);
      if (!bp && !bs) check({tag, ".rx_byte"}, {24'b0, v_byte}, {24'b0, rb});
      check_state(tag);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
